splat_ddr_fetch: RTL and testbench
==================================

// Module: splat_ddr_fetch
// PURPOSE
//  Read-side DDR3 master for the splat path. On start it streams word_count 64-bit words
//  from base_addr into the splat word FIFO, which sits between this block and splat_reader.
//  Issues Avalon-MM burst reads only when FIFO space is guaranteed (credit scheme), so the
//  FIFO never drops a word. Supports abort with clean drain of in-flight DDR returns.
// PARAMETERS
//  FIFO_DEPTH  32  entries in the downstream splat FIFO
//  MAX_BURST   8   max words per DDR burst (power of 2, <= FIFO_DEPTH)
//  ADDR_W      29  DDR word-address width (64-bit words)
//  LEN_W       20  transfer length width (words)
// PORTS
//  clk              in   1       clock
//  reset            in   1       async reset, active high
//  start            in   1       1-cycle pulse: begin transfer (ignored when busy=1)
//  base_addr        in   ADDR_W  first word address, sampled on start
//  word_count       in   LEN_W   words to fetch, sampled on start
//  abort            in   1       1-cycle pulse: cancel transfer (ignored when busy=0)
//  busy             out  1       high from start-accept until done/flush pulse
//  done             out  1       1-cycle pulse: all words written to FIFO
//  ddr_address      out  ADDR_W  burst start word address
//  ddr_burstcount   out  4       burst length, 1..MAX_BURST
//  ddr_read         out  1       read request; held with addr/burst until !ddr_waitrequest
//  ddr_waitrequest  in   1       slave stall
//  ddr_readdata     in   64      return data
//  ddr_readdatavalid in  1       return data valid
//  fifo_wr_data     out  64      to FIFO wr_data
//  fifo_wr_en       out  1       to FIFO wr_en
//  fifo_count       in   6       FIFO occupancy
//  fifo_flush       out  1       1-cycle pulse to FIFO flush after abort drain
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-transfer drops all in-flight state;
//   late ddr_readdatavalid after reset release is ignored (fifo_wr_en stays 0 in IDLE).
//  States: IDLE -> REQ (start, word_count!=0) | DONE (start, word_count==0);
//   REQ -> WAIT when last burst accepted; WAIT -> DONE when outstanding==0 and all written;
//   REQ/WAIT -> ABORT on abort; ABORT -> IDLE when outstanding==0 (pulse fifo_flush);
//   DONE -> IDLE after 1 cycle (done=1 that cycle).
//  Data path: fifo_wr_data/fifo_wr_en are registered copies of ddr_readdata/readdatavalid
//   (1-cycle latency). In ABORT, fifo_wr_en forced 0 (returns discarded but still counted).
//  Credit: outstanding = words accepted by DDR not yet written to FIFO; +burst on accept edge
//   (ddr_read & !ddr_waitrequest), -1 on each edge with a registered return; both may occur
//   together. Issue next burst only if FIFO_DEPTH - fifo_count - outstanding >= burst.
//  burst = min(MAX_BURST, remaining_to_request). ddr_address += burst after each accept.
//  Request hold: once ddr_read=1, address/burstcount/read stay stable until accepted, even
//   if abort arrives; the accepted burst is then drained in ABORT.
//  Widths: outstanding and credit use 7 bits (no underflow; credit never negative by design).
//  Simultaneous start+abort in IDLE: start wins, abort ignored. abort same cycle as done: ignored.
//  busy=1 in REQ, WAIT, ABORT; busy=0 in IDLE and DONE.
// TESTING
//  1. base=0x100, count=20, no stalls, FIFO drained continuously -> bursts 8@0x100,8@0x108,4@0x110;
//     20 fifo_wr_en in order; done pulses once; busy falls with done.
//  2. count=40, consumer never pops -> exactly 32 words written, ddr_read stays 0 afterwards;
//     pop 8 -> one 8-word burst issued; fifo_count never exceeds 32.
//  3. ddr_waitrequest held 5 cycles on first burst -> address/burstcount/read stable all 5 cycles.
//  4. abort with 12 words outstanding -> no new requests; 0 fifo_wr_en after abort;
//     fifo_flush pulses 1 cycle after 12th return; busy then 0; done never asserted.
//  5. start with word_count=0 -> no ddr_read, done pulse next cycle.
//  6. reset asserted mid-burst then released with returns still arriving -> outputs 0, no FIFO writes;
//     new start proceeds normally.

Source files
------------

// File: rtl/splat_ddr_fetch.sv
// splat_ddr_fetch: credit-gated Avalon-MM burst reader feeding the splat word FIFO.
// Bursts are only issued when the FIFO is guaranteed room for every returning word.
module splat_ddr_fetch #(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int ADDR_W     = 29,
    parameter int LEN_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ddr_address,
    output logic [3:0]        ddr_burstcount,
    output logic              ddr_read,
    input  logic              ddr_waitrequest,
    input  logic [63:0]       ddr_readdata,
    input  logic              ddr_readdatavalid,
    output logic [63:0]       fifo_wr_data,
    output logic              fifo_wr_en,
    input  logic [5:0]        fifo_count,
    output logic              fifo_flush
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ABORT,
        DONE
    } state_t;

    localparam logic [6:0]       DEPTH7 = 7'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] MAXB   = LEN_W'(MAX_BURST);

    state_t            state;
    state_t            state_nx;

    logic [LEN_W-1:0]  req_left;
    logic [LEN_W-1:0]  wr_left;
    logic [6:0]        outstanding;
    logic              ret_valid;

    logic [LEN_W-1:0]  burst_len;
    logic [3:0]        burst;
    logic [6:0]        used;
    logic [6:0]        credit;
    logic              can_issue;
    logic              issue;
    logic              accept;
    logic              last_accept;
    logic              retire;
    logic              drain_done;
    logic              all_written;

    // Burst sizing and credit: words in the FIFO plus words still owed by DDR
    // must leave room for the whole next burst.
    always_comb begin
        burst_len   = (req_left > MAXB) ? MAXB : req_left;
        burst       = burst_len[3:0];
        used        = {1'b0, fifo_count} + outstanding;
        credit      = DEPTH7 - used;
        can_issue   = (used <= DEPTH7) && (credit >= {3'b000, burst});
        issue       = (state == REQ) && !ddr_read
                      && (req_left != '0) && can_issue;
        accept      = ddr_read && !ddr_waitrequest;
        last_accept = accept && (req_left == LEN_W'(ddr_burstcount));
        retire      = ret_valid && (outstanding != 7'd0);
        // The final return may still be in the capture register when the
        // drain finishes; it retires on the same edge the FSM leaves ABORT.
        drain_done  = !ddr_read
                      && ((outstanding == 7'd0)
                          || ((outstanding == 7'd1) && ret_valid));
        all_written = (outstanding == 7'd0) && (wr_left == '0);
    end

    // Returns only reach the FIFO while a live transfer is running.
    assign fifo_wr_en = ret_valid && ((state == REQ) || (state == WAIT));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        fifo_flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (word_count == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = ABORT;
                end else if (last_accept) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (all_written) begin
                    state_nx = DONE;
                end else if (abort) begin
                    state_nx = ABORT;
                end
            end
            ABORT: begin
                busy = 1'b1;
                if (drain_done) begin
                    fifo_flush = 1'b1;
                    state_nx   = IDLE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Avalon request: once raised, address/burstcount/read hold until accepted,
    // even across an abort, so the slave never sees a withdrawn request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ddr_read       <= 1'b0;
            ddr_address    <= '0;
            ddr_burstcount <= 4'd0;
            req_left       <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                ddr_address <= base_addr;
                req_left    <= word_count;
            end
            if (issue) begin
                ddr_read       <= 1'b1;
                ddr_burstcount <= burst;
            end else if (accept) begin
                ddr_read    <= 1'b0;
                ddr_address <= ddr_address + ADDR_W'(ddr_burstcount);
                req_left    <= req_left - LEN_W'(ddr_burstcount);
            end
        end
    end

    // Words owed by DDR: grow by a burst on accept, shrink by one per return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= 7'd0;
        end else if ((state == IDLE) && start) begin
            outstanding <= 7'd0;
        end else begin
            outstanding <= outstanding
                           + (accept ? {3'b000, ddr_burstcount} : 7'd0)
                           - (retire ? 7'd1 : 7'd0);
        end
    end

    // Words still to be written to the FIFO for the current transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_left <= '0;
        end else if ((state == IDLE) && start) begin
            wr_left <= word_count;
        end else if (fifo_wr_en && (wr_left != '0)) begin
            wr_left <= wr_left - 1'b1;
        end
    end

    // One-cycle capture of DDR returns; stale returns outside a transfer are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_valid    <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            ret_valid    <= ddr_readdatavalid && busy;
            fifo_wr_data <= ddr_readdata;
        end
    end

endmodule

// File: tb/tb_splat_ddr_fetch.sv
// tb_splat_ddr_fetch: directed bench with a DDR slave model and a FIFO occupancy model.
// Expected bursts, data and pulse timing are hand-derived for each step.
module tb_splat_ddr_fetch;

    localparam int AW = 29;
    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] word_count;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] ddr_address;
    logic [3:0]    ddr_burstcount;
    logic          ddr_read;
    logic          ddr_waitrequest;
    logic [63:0]   ddr_readdata;
    logic          ddr_readdatavalid;
    logic [63:0]   fifo_wr_data;
    logic          fifo_wr_en;
    logic [5:0]    fifo_count;
    logic          fifo_flush;

    always #5 clk = ~clk;

    splat_ddr_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .ddr_address       (ddr_address),
        .ddr_burstcount    (ddr_burstcount),
        .ddr_read          (ddr_read),
        .ddr_waitrequest   (ddr_waitrequest),
        .ddr_readdata      (ddr_readdata),
        .ddr_readdatavalid (ddr_readdatavalid),
        .fifo_wr_data      (fifo_wr_data),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_count        (fifo_count),
        .fifo_flush        (fifo_flush)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int fcount = 0, fmax = 0;
    int wr_pend = 0, pop_pend = 0, flush_pend = 0;
    bit pop_en = 1'b0;
    int pop_budget = 0;
    logic [63:0] wr_q[$];

    logic [AW-1:0] acc_addr[$];
    logic [3:0]    acc_len[$];
    logic [AW-1:0] retq[$];
    int            rdyq[$];
    int stall_left = 0, stall_seen = 0, unstable = 0, rd_cycles = 0;
    bit hold_valid = 1'b0;
    logic [AW-1:0] hold_a;
    logic [3:0]    hold_b;
    bit ret_hold = 1'b0;
    int last_rdv = 0, rdv_cnt = 0;

    int   done_cnt = 0, done_cyc = 0;
    logic done_busy = 1'b0, done_prev_busy = 1'b0, prev_busy = 1'b0;
    int   flush_cnt = 0, flush_cyc = 0;

    function automatic logic [63:0] data_of(input logic [AW-1:0] a);
        return {32'hD0D0_0000, 3'b000, a};
    endfunction

    // DDR slave, FIFO model and pulse monitor, one slot per clock after the edge.
    initial begin
        ddr_waitrequest   = 1'b0;
        ddr_readdatavalid = 1'b0;
        ddr_readdata      = '0;
        fifo_count        = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            fcount = fcount + wr_pend - pop_pend;
            if (flush_pend != 0) fcount = 0;
            if (fcount > fmax) fmax = fcount;
            fifo_count = 6'(fcount);
            wr_pend  = fifo_wr_en ? 1 : 0;
            if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
            pop_pend = ((pop_en || pop_budget > 0) && fcount > 0) ? 1 : 0;
            if (pop_pend != 0 && !pop_en && pop_budget > 0) pop_budget--;
            flush_pend = fifo_flush ? 1 : 0;
            if (done) begin
                done_cnt++;
                done_cyc       = cyc;
                done_busy      = busy;
                done_prev_busy = prev_busy;
            end
            if (fifo_flush) begin
                flush_cnt++;
                flush_cyc = cyc;
            end
            prev_busy = busy;
            if (ddr_read) begin
                rd_cycles++;
                if (hold_valid && (ddr_address !== hold_a || ddr_burstcount !== hold_b))
                    unstable++;
                if (stall_left > 0) begin
                    if (!hold_valid) begin
                        hold_a     = ddr_address;
                        hold_b     = ddr_burstcount;
                        hold_valid = 1'b1;
                    end
                    stall_seen++;
                    stall_left--;
                    ddr_waitrequest = 1'b1;
                end else begin
                    hold_valid      = 1'b0;
                    ddr_waitrequest = 1'b0;
                    acc_addr.push_back(ddr_address);
                    acc_len.push_back(ddr_burstcount);
                    for (int i = 0; i < int'(ddr_burstcount); i++) begin
                        retq.push_back(ddr_address + AW'(i));
                        rdyq.push_back(cyc + 3);
                    end
                end
            end else begin
                ddr_waitrequest = 1'b0;
            end
            if (!ret_hold && retq.size() > 0 && rdyq[0] <= cyc) begin
                ddr_readdatavalid = 1'b1;
                ddr_readdata      = data_of(retq.pop_front());
                void'(rdyq.pop_front());
                last_rdv = cyc;
                rdv_cnt++;
            end else begin
                ddr_readdatavalid = 1'b0;
                ddr_readdata      = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input int n, input bit with_abort);
        base_addr  = b;
        word_count = LW'(n);
        start      = 1'b1;
        abort      = with_abort;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < bound) begin
            tick(1);
            n++;
        end
        chk(tag, done_cnt == d0, 1'b0);
    endtask

    task automatic chk_data(input string tag, input int w0, input logic [AW-1:0] b, input int n);
        int errs = 0;
        if (wr_q.size() < w0 + n) errs = n;
        else
            for (int i = 0; i < n; i++)
                if (wr_q[w0 + i] !== data_of(b + AW'(i))) errs++;
        chk(tag, errs, 0);
    endtask

    initial begin
        int a0, w0, d0, f0, r0, rc, cs, n;
        logic [AW-1:0] ea [3];
        logic [3:0]    el [3];
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        tick(3);
        chk("rst read", ddr_read, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wr_en", fifo_wr_en, 0);
        chk("rst flush", fifo_flush, 0);
        chk("rst burst", ddr_burstcount, 0);
        reset = 1'b0;
        tick(2);

        // 1: 20 words, free-running consumer, abort with start is ignored
        pop_en = 1'b1;
        a0 = acc_addr.size(); w0 = wr_q.size(); d0 = done_cnt;
        start_xfer(29'h100, 20, 1'b1);
        wait_done(d0, 200, "t1 timeout");
        tick(2);
        ea = '{29'h100, 29'h108, 29'h110};
        el = '{4'd8, 4'd8, 4'd4};
        chk("t1 bursts", acc_addr.size() - a0, 3);
        if (acc_addr.size() >= a0 + 3)
            for (int i = 0; i < 3; i++) begin
                chk("t1 addr", acc_addr[a0 + i], ea[i]);
                chk("t1 len", acc_len[a0 + i], el[i]);
            end
        chk("t1 words", wr_q.size() - w0, 20);
        chk_data("t1 data", w0, 29'h100, 20);
        chk("t1 done once", done_cnt - d0, 1);
        chk("t1 busy at done", done_busy, 0);
        chk("t1 busy before done", done_prev_busy, 1);

        // 2: consumer stalled, credit caps writes at FIFO depth
        pop_en = 1'b0;
        fmax = fcount;
        a0 = acc_addr.size(); w0 = wr_q.size(); d0 = done_cnt;
        start_xfer(29'h200, 40, 1'b0);
        tick(70);
        chk("t2 words capped", wr_q.size() - w0, 32);
        chk("t2 bursts capped", acc_addr.size() - a0, 4);
        chk("t2 level", fcount, 32);
        rc = rd_cycles;
        tick(20);
        chk("t2 no read", rd_cycles - rc, 0);
        chk("t2 still busy", busy, 1);
        pop_budget = 8;
        wait_done(d0, 100, "t2 timeout");
        tick(2);
        chk("t2 one more burst", acc_addr.size() - a0, 5);
        if (acc_addr.size() >= a0 + 5) begin
            chk("t2 last addr", acc_addr[a0 + 4], 29'h220);
            chk("t2 last len", acc_len[a0 + 4], 8);
        end
        chk("t2 words", wr_q.size() - w0, 40);
        chk_data("t2 data", w0, 29'h200, 40);
        chk("t2 max level", fmax > 32, 0);
        pop_en = 1'b1;
        tick(50);

        // 3: first burst stalled 5 cycles
        a0 = acc_addr.size(); w0 = wr_q.size(); d0 = done_cnt;
        stall_seen = 0; unstable = 0;
        stall_left = 5;
        start_xfer(29'h300, 8, 1'b0);
        wait_done(d0, 100, "t3 timeout");
        chk("t3 stall cycles", stall_seen, 5);
        chk("t3 stable", unstable, 0);
        chk("t3 bursts", acc_addr.size() - a0, 1);
        if (acc_addr.size() >= a0 + 1) begin
            chk("t3 addr", acc_addr[a0], 29'h300);
            chk("t3 len", acc_len[a0], 8);
        end
        chk_data("t3 data", w0, 29'h300, 8);
        tick(5);

        // 4: abort with 12 words outstanding
        ret_hold = 1'b1;
        a0 = acc_addr.size(); d0 = done_cnt; f0 = flush_cnt; r0 = rdv_cnt;
        start_xfer(29'h400, 12, 1'b0);
        tick(15);
        chk("t4 bursts", acc_addr.size() - a0, 2);
        chk("t4 busy", busy, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        w0 = wr_q.size();
        tick(3);
        ret_hold = 1'b0;
        n = 0;
        while (flush_cnt == f0 && n < 60) begin
            tick(1);
            n++;
        end
        chk("t4 flush timeout", flush_cnt == f0, 0);
        tick(2);
        chk("t4 flush once", flush_cnt - f0, 1);
        chk("t4 returns", rdv_cnt - r0, 12);
        chk("t4 flush timing", flush_cyc - last_rdv, 1);
        chk("t4 no writes", wr_q.size() - w0, 0);
        chk("t4 no new req", acc_addr.size() - a0, 2);
        chk("t4 busy after", busy, 0);
        chk("t4 no done", done_cnt - d0, 0);

        // 5: zero-length transfer
        a0 = acc_addr.size(); d0 = done_cnt; cs = cyc;
        start_xfer(29'h700, 0, 1'b0);
        tick(2);
        chk("t5 done once", done_cnt - d0, 1);
        chk("t5 done timing", done_cyc - cs, 1);
        chk("t5 no read", acc_addr.size() - a0, 0);
        chk("t5 busy", done_busy, 0);

        // 6: reset mid-burst with returns still arriving
        a0 = acc_addr.size();
        start_xfer(29'h500, 16, 1'b0);
        n = 0;
        while (acc_addr.size() == a0 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t6 accept timeout", acc_addr.size() == a0, 0);
        tick(2);
        reset = 1'b1;
        #1;
        chk("t6 rst read", ddr_read, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst wr_en", fifo_wr_en, 0);
        chk("t6 rst addr", ddr_address, 0);
        w0 = wr_q.size();
        tick(2);
        reset = 1'b0;
        n = 0;
        while (retq.size() > 0 && n < 60) begin
            tick(1);
            n++;
        end
        tick(3);
        chk("t6 late returns dropped", wr_q.size() - w0, 0);
        chk("t6 idle busy", busy, 0);
        a0 = acc_addr.size(); w0 = wr_q.size(); d0 = done_cnt;
        start_xfer(29'h600, 8, 1'b0);
        wait_done(d0, 100, "t6 timeout");
        chk("t6 bursts", acc_addr.size() - a0, 1);
        if (acc_addr.size() >= a0 + 1)
            chk("t6 addr", acc_addr[a0], 29'h600);
        chk_data("t6 data", w0, 29'h600, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
